// File: rtl/fpadd_sched_pkg.sv
// rtl/fpadd_sched_pkg.sv - shared types and widths for the FP adder scheduler
package fpadd_sched_pkg;

    localparam int EXP_W = 8;
    localparam int MAN_W = 23;
    localparam int FP_W  = 1 + EXP_W + MAN_W;

    typedef logic [FP_W-1:0] fp_word_t;

    typedef enum logic [1:0] {
        IDLE,
        EVAL,
        RESP
    } state_t;

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - round-robin pick of the first request at or above ptr, with wrap
module rr_arbiter #(
    parameter int N = 4
) (
    input  logic [N-1:0]         req,
    input  logic [$clog2(N)-1:0] ptr,
    output logic [N-1:0]         gnt,
    output logic [$clog2(N)-1:0] gnt_idx,
    output logic                 any
);

    localparam int IW = $clog2(N);

    logic found;

    always_comb begin
        gnt     = '0;
        gnt_idx = '0;
        any     = |req;
        found   = 1'b0;
        for (int k = 0; k < N; k++) begin
            if (!found && req[IW'((int'(ptr) + k) % N)]) begin
                found                         = 1'b1;
                gnt[IW'((int'(ptr) + k) % N)] = 1'b1;
                gnt_idx                       = IW'((int'(ptr) + k) % N);
            end
        end
    end

endmodule

// File: rtl/fpadd_scheduler.sv
// rtl/fpadd_scheduler.sv - time-shares one combinational FP adder among NUM_REQ requesters
module fpadd_scheduler
    import fpadd_sched_pkg::*;
#(
    parameter int NUM_REQ     = 4,
    parameter int EVAL_CYCLES = 2
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic [NUM_REQ-1:0]                req_valid,
    output logic [NUM_REQ-1:0]                req_ready,
    input  logic [NUM_REQ-1:0][FP_W-1:0]      req_a,
    input  logic [NUM_REQ-1:0][FP_W-1:0]      req_b,
    output logic [NUM_REQ-1:0]                resp_valid,
    input  logic [NUM_REQ-1:0]                resp_ready,
    output fp_word_t                          resp_result,
    output logic [$clog2(NUM_REQ)-1:0]        grant_id,
    output logic                              busy,
    output fp_word_t                          fp_a,
    output fp_word_t                          fp_b,
    input  fp_word_t                          fp_result
);

    localparam int ID_W  = $clog2(NUM_REQ);
    localparam int CNT_W = (EVAL_CYCLES > 1) ? $clog2(EVAL_CYCLES) : 1;

    state_t            state, state_n;
    logic [ID_W-1:0]   rr_ptr;
    logic [CNT_W-1:0]  cnt;
    fp_word_t          result_q;

    logic [NUM_REQ-1:0] arb_gnt;
    logic [ID_W-1:0]    arb_idx;
    logic               arb_any;

    rr_arbiter #(.N(NUM_REQ)) u_arb (
        .req     (req_valid),
        .ptr     (rr_ptr),
        .gnt     (arb_gnt),
        .gnt_idx (arb_idx),
        .any     (arb_any)
    );

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_n;
    end

    always_comb begin
        state_n    = state;
        req_ready  = '0;
        resp_valid = '0;
        case (state)
            IDLE: begin
                req_ready = arb_gnt;
                if (arb_any) state_n = EVAL;
            end
            EVAL: begin
                if (cnt == '0) state_n = RESP;
            end
            RESP: begin
                resp_valid[grant_id] = 1'b1;
                if (resp_ready[grant_id]) state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    // Pointer moves only on response completion so a requester keeps its turn through backpressure.
    always_ff @(posedge clk) begin
        if (reset) begin
            rr_ptr   <= '0;
            grant_id <= '0;
            cnt      <= '0;
            fp_a     <= '0;
            fp_b     <= '0;
            result_q <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (arb_any) begin
                        fp_a     <= req_a[arb_idx];
                        fp_b     <= req_b[arb_idx];
                        grant_id <= arb_idx;
                        cnt      <= CNT_W'(EVAL_CYCLES - 1);
                    end
                end
                EVAL: begin
                    if (cnt == '0) result_q <= fp_result;
                    else           cnt      <= cnt - CNT_W'(1);
                end
                RESP: begin
                    if (resp_ready[grant_id])
                        rr_ptr <= (grant_id == ID_W'(NUM_REQ - 1)) ? '0 : grant_id + ID_W'(1);
                end
                default: ;
            endcase
        end
    end

    assign resp_result = result_q;
    assign busy        = (state != IDLE);

endmodule

// File: tb/tb_fpadd_scheduler.sv
// tb/tb_fpadd_scheduler.sv - directed table-driven bench for fpadd_scheduler
module tb_fpadd_scheduler;
    import fpadd_sched_pkg::*;

    localparam int NUM_REQ     = 4;
    localparam int EVAL_CYCLES = 2;

    logic clk = 1'b0;
    logic reset;
    logic [NUM_REQ-1:0]       req_valid, req_ready, resp_valid, resp_ready;
    logic [NUM_REQ-1:0][31:0] req_a, req_b;
    logic [31:0]              resp_result, fp_a, fp_b, fp_result;
    logic [1:0]               grant_id;
    logic                     busy;

    always #5 clk = ~clk;

    fpadd_scheduler #(.NUM_REQ(NUM_REQ), .EVAL_CYCLES(EVAL_CYCLES)) dut (
        .clk         (clk),
        .reset       (reset),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_a       (req_a),
        .req_b       (req_b),
        .resp_valid  (resp_valid),
        .resp_ready  (resp_ready),
        .resp_result (resp_result),
        .grant_id    (grant_id),
        .busy        (busy),
        .fp_a        (fp_a),
        .fp_b        (fp_b),
        .fp_result   (fp_result)
    );

    // Datapath stand-in: known sums, but garbage until the operands have been stable long enough.
    function automatic logic [31:0] dp_sum(input logic [31:0] a, input logic [31:0] b);
        case ({a, b})
            64'h3FC00000_40100000: return 32'h40700000;
            64'hBF920000_3F921000: return 32'h3A000000;
            64'h7F800000_FF800000: return 32'h7FC00000;
            64'h80000000_80000000: return 32'h80000000;
            64'h00000001_00000001: return 32'h00000002;
            64'h40000000_C0000000: return 32'h00000000;
            64'h3F800000_3F800000: return 32'h40000000;
            64'h41200000_3F800000: return 32'h41300000;
            default:               return 32'h0BAD0BAD;
        endcase
    endfunction

    logic [31:0] last_a = '0, last_b = '0;
    int settle = 0;
    always @(negedge clk) begin
        if (fp_a !== last_a || fp_b !== last_b) begin
            last_a <= fp_a;
            last_b <= fp_b;
            settle <= 0;
        end else if (settle < 100) begin
            settle <= settle + 1;
        end
    end
    assign fp_result = (settle >= EVAL_CYCLES - 1) ? dp_sum(fp_a, fp_b) : 32'hDEADBEEF;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int total = 0, bad = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h, want %h", name, act, exp);
        end
    endtask

    // Called just after a negedge; returns at negedge+1 of the accept cycle.
    task automatic wait_ready(input int id, output int t);
        t = -1;
        for (int k = 0; k < 20; k++) begin
            #1;
            if (req_ready[id]) begin
                t = cyc;
                break;
            end
            @(negedge clk);
        end
        chk("accept_seen", 32'(t >= 0), 32'd1);
    endtask

    task automatic wait_resp(output int t);
        t = -1;
        for (int k = 0; k < 20; k++) begin
            #1;
            if (|resp_valid) begin
                t = cyc;
                break;
            end
            @(negedge clk);
        end
        chk("resp_seen", 32'(t >= 0), 32'd1);
    endtask

    task automatic wait_idle();
        for (int k = 0; k < 40; k++) begin
            #1;
            if (!busy) break;
            @(negedge clk);
        end
        chk("idle_reached", 32'(busy), 32'd0);
    endtask

    task automatic do_op(input int id, input logic [31:0] a, input logic [31:0] b, input logic [31:0] r);
        int t_acc, t_rsp;
        @(negedge clk);
        req_valid[id] = 1'b1;
        req_a[id] = a;
        req_b[id] = b;
        wait_ready(id, t_acc);
        chk("accept_onehot", 32'(req_ready), 32'(1 << id));
        @(negedge clk);
        req_valid[id] = 1'b0;
        wait_resp(t_rsp);
        chk("latency", 32'(t_rsp - t_acc), 32'(EVAL_CYCLES + 1));
        chk("resp_valid_onehot", 32'(resp_valid), 32'(1 << id));
        chk("resp_result", resp_result, r);
        chk("grant_id", 32'(grant_id), 32'(id));
        resp_ready[id] = 1'b1;
        @(negedge clk);
        #1;
        chk("busy_after_resp", 32'(busy), 32'd0);
        chk("resp_valid_after", 32'(resp_valid), 32'd0);
        resp_ready[id] = 1'b0;
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
    endtask

    function automatic int oh_idx(input logic [NUM_REQ-1:0] v);
        for (int i = 0; i < NUM_REQ; i++) if (v[i]) return i;
        return -1;
    endfunction

    typedef struct {
        int          id;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] r;
    } vec_t;
    vec_t vecs[8];

    initial begin
        int t0, t1, n, seen;
        int g[5], tt[5];
        int exp_g[5];

        vecs[0] = '{0, 32'h3FC00000, 32'h40100000, 32'h40700000};
        vecs[1] = '{1, 32'hBF920000, 32'h3F921000, 32'h3A000000};
        vecs[2] = '{2, 32'h7F800000, 32'hFF800000, 32'h7FC00000};
        vecs[3] = '{3, 32'h80000000, 32'h80000000, 32'h80000000};
        vecs[4] = '{0, 32'h00000001, 32'h00000001, 32'h00000002};
        vecs[5] = '{3, 32'h40000000, 32'hC0000000, 32'h00000000};
        vecs[6] = '{1, 32'h3F800000, 32'h3F800000, 32'h40000000};
        vecs[7] = '{2, 32'h41200000, 32'h3F800000, 32'h41300000};
        exp_g = '{0, 1, 2, 3, 0};

        reset = 1'b1;
        req_valid = '0;
        resp_ready = '0;
        req_a = '0;
        req_b = '0;
        repeat (2) @(negedge clk);
        #1;
        chk("rst_req_ready", 32'(req_ready), 32'd0);
        chk("rst_resp_valid", 32'(resp_valid), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_grant_id", 32'(grant_id), 32'd0);
        chk("rst_fp_a", fp_a, 32'd0);
        chk("rst_fp_b", fp_b, 32'd0);
        chk("rst_result", resp_result, 32'd0);
        reset = 1'b0;

        for (int i = 0; i < 8; i++) do_op(vecs[i].id, vecs[i].a, vecs[i].b, vecs[i].r);

        // Fairness: all requesters valid, responses accepted immediately.
        pulse_reset();
        req_a[0] = 32'h3F800000; req_b[0] = 32'h3F800000;
        req_a[1] = 32'h41200000; req_b[1] = 32'h3F800000;
        req_a[2] = 32'h3FC00000; req_b[2] = 32'h40100000;
        req_a[3] = 32'h00000001; req_b[3] = 32'h00000001;
        req_valid = 4'hF;
        resp_ready = 4'hF;
        n = 0;
        for (int k = 0; k < 60 && n < 5; k++) begin
            #1;
            if (|req_ready) begin
                g[n] = oh_idx(req_ready);
                tt[n] = cyc;
                n++;
            end
            @(negedge clk);
        end
        req_valid = '0;
        chk("fair_count", 32'(n), 32'd5);
        for (int i = 0; i < 5; i++) begin
            if (i < n) begin
                chk("fair_order", 32'(g[i]), 32'(exp_g[i]));
                if (i > 0) chk("fair_spacing", 32'(tt[i] - tt[i-1]), 32'(EVAL_CYCLES + 2));
            end
        end
        wait_idle();
        resp_ready = '0;

        // Backpressure on req 0 with req 1 waiting and a foreign resp_ready that must be ignored.
        @(negedge clk);
        req_valid[0] = 1'b1;
        req_a[0] = 32'h3FC00000; req_b[0] = 32'h40100000;
        wait_ready(0, t0);
        @(negedge clk);
        req_valid[0] = 1'b0;
        req_valid[1] = 1'b1;
        req_a[1] = 32'hBF920000; req_b[1] = 32'h3F921000;
        resp_ready[2] = 1'b1;
        wait_resp(t1);
        for (int k = 0; k < 5; k++) begin
            if (k > 0) begin
                @(negedge clk);
                #1;
            end
            chk("bp_resp_valid", 32'(resp_valid), 32'h1);
            chk("bp_result", resp_result, 32'h40700000);
            chk("bp_req_ready", 32'(req_ready), 32'd0);
            chk("bp_fp_a", fp_a, 32'h3FC00000);
        end
        @(negedge clk);
        resp_ready[0] = 1'b1;
        #1;
        chk("bp_6th_valid", 32'(resp_valid), 32'h1);
        @(negedge clk);
        resp_ready[0] = 1'b0;
        resp_ready[2] = 1'b0;
        #1;
        chk("bp_busy_done", 32'(busy), 32'd0);
        chk("bp_next_grant", 32'(req_ready), 32'h2);
        @(negedge clk);
        req_valid[1] = 1'b0;
        wait_resp(t1);
        chk("cancel_result", resp_result, 32'h3A000000);
        chk("cancel_grant", 32'(grant_id), 32'd1);
        resp_ready[1] = 1'b1;
        @(negedge clk);
        resp_ready[1] = 1'b0;

        // Sparse wrap: rr_ptr is 2, only req 3 and req 1 valid.
        req_valid = 4'b1010;
        req_a[3] = 32'h3F800000; req_b[3] = 32'h3F800000;
        req_a[1] = 32'h41200000; req_b[1] = 32'h3F800000;
        #1;
        chk("wrap_first", 32'(req_ready), 32'h8);
        @(negedge clk);
        req_valid[3] = 1'b0;
        wait_resp(t1);
        chk("wrap_first_result", resp_result, 32'h40000000);
        resp_ready[3] = 1'b1;
        @(negedge clk);
        resp_ready[3] = 1'b0;
        #1;
        chk("wrap_second", 32'(req_ready), 32'h2);
        @(negedge clk);
        req_valid[1] = 1'b0;
        wait_resp(t1);
        chk("wrap_second_result", resp_result, 32'h41300000);
        resp_ready[1] = 1'b1;
        @(negedge clk);
        resp_ready[1] = 1'b0;

        // Reset while in EVAL: transaction dropped, rr_ptr back to 0.
        req_valid[3] = 1'b1;
        req_a[3] = 32'h7F800000; req_b[3] = 32'hFF800000;
        #1;
        chk("rst_eval_accept", 32'(req_ready), 32'h8);
        @(negedge clk);
        req_valid[3] = 1'b0;
        resp_ready = 4'hF;
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk("rst_eval_busy", 32'(busy), 32'd0);
        chk("rst_eval_fp_a", fp_a, 32'd0);
        chk("rst_eval_grant", 32'(grant_id), 32'd0);
        seen = 0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            #1;
            if (|resp_valid) seen = 1;
        end
        chk("rst_eval_no_resp", 32'(seen), 32'd0);
        resp_ready = '0;
        @(negedge clk);
        req_valid = 4'b0110;
        req_a[1] = 32'h80000000; req_b[1] = 32'h80000000;
        req_a[2] = 32'h00000001; req_b[2] = 32'h00000001;
        #1;
        chk("rst_ptr_zero", 32'(req_ready), 32'h2);
        @(negedge clk);
        req_valid[1] = 1'b0;
        wait_resp(t1);
        chk("negzero_result", resp_result, 32'h80000000);
        resp_ready[1] = 1'b1;
        @(negedge clk);
        resp_ready[1] = 1'b0;
        #1;
        chk("req2_granted", 32'(req_ready), 32'h4);
        @(negedge clk);
        req_valid[2] = 1'b0;
        wait_resp(t1);
        chk("req2_result", resp_result, 32'h00000002);
        chk("req2_resp_valid", 32'(resp_valid), 32'h4);
        resp_ready[2] = 1'b1;
        @(negedge clk);
        resp_ready[2] = 1'b0;
        wait_idle();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
